// File: rtl/registro_paralelo_serie_tx.sv
// rtl/registro_paralelo_serie_tx.sv - parallel-in / serial-out transmitter with ready/busy/done handshake
// Captures a word in IDLE, shifts it out one bit per clock, then pulses done for one cycle.
module registro_paralelo_serie_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk44kHz,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] datoIn,
  output logic             ready,
  output logic             busy,
  output logic             serialOut,
  output logic             bitValid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Outputs are registered alongside the state, so serialOut is loaded with the
  // bit that the shift register will present in the coming cycle.
  always_ff @(posedge clk44kHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      count     <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      serialOut <= 1'b0;
      bitValid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state     <= SHIFT;
            shreg     <= datoIn;
            count     <= CNT_FULL;
            ready     <= 1'b0;
            busy      <= 1'b1;
            bitValid  <= 1'b1;
            serialOut <= lead_bit(datoIn);
          end
        end
        SHIFT: begin
          shreg <= shifted(shreg);
          if (count != '0) begin
            count <= count - CNT_ONE;
          end
          if (count == CNT_ONE) begin
            state     <= DONE;
            bitValid  <= 1'b0;
            serialOut <= 1'b0;
            done      <= 1'b1;
          end else begin
            serialOut <= lead_bit(shifted(shreg));
          end
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          ready     <= 1'b1;
          busy      <= 1'b0;
          serialOut <= 1'b0;
          bitValid  <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_registro_paralelo_serie_tx.sv
// tb/tb_registro_paralelo_serie_tx.sv - self-checking bench for registro_paralelo_serie_tx
// Three instances (4-bit MSB-first, 4-bit LSB-first, 8-bit MSB-first) against a timing model.
module tb_registro_paralelo_serie_tx;

  logic       clk44kHz = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] dato4;
  logic [7:0] dato8;

  logic ready     [3];
  logic busy      [3];
  logic serialOut [3];
  logic bitValid  [3];
  logic done      [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: age = cycles since the accepting edge (0 = idle); word = captured value.
  int         age  [3];
  logic [7:0] word [3];

  always #5 clk44kHz = ~clk44kHz;

  registro_paralelo_serie_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk44kHz(clk44kHz), .reset(reset), .load(load), .datoIn(dato4),
    .ready(ready[0]), .busy(busy[0]), .serialOut(serialOut[0]),
    .bitValid(bitValid[0]), .done(done[0])
  );

  registro_paralelo_serie_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk44kHz(clk44kHz), .reset(reset), .load(load), .datoIn(dato4),
    .ready(ready[1]), .busy(busy[1]), .serialOut(serialOut[1]),
    .bitValid(bitValid[1]), .done(done[1])
  );

  registro_paralelo_serie_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8 (
    .clk44kHz(clk44kHz), .reset(reset), .load(load), .datoIn(dato8),
    .ready(ready[2]), .busy(busy[2]), .serialOut(serialOut[2]),
    .bitValid(bitValid[2]), .done(done[2])
  );

  function automatic int wd(input int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic bit msb(input int i);
    return (i != 1);
  endfunction

  // Expected {ready, busy, bitValid, serialOut, done} from the spec timing:
  // bits in ages 1..W, done at age W+1, idle otherwise.
  function automatic logic [4:0] expv(input int i);
    logic in_bits;
    logic sbit;
    int   idx;
    in_bits = (age[i] >= 1) && (age[i] <= wd(i));
    sbit    = 1'b0;
    if (in_bits) begin
      idx  = msb(i) ? (wd(i) - age[i]) : (age[i] - 1);
      sbit = word[i][idx];
    end
    return {age[i] == 0, age[i] != 0, in_bits, sbit, age[i] == wd(i) + 1};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (age[i] == 0) begin
        if (load) begin
          age[i]  = 1;
          word[i] = (i == 2) ? dato8 : {4'h0, dato4};
        end
      end else if (age[i] == wd(i) + 1) begin
        age[i] = 0;
      end else begin
        age[i] = age[i] + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = expv(i);
      obs = {ready[i], busy[i], bitValid[i], serialOut[i], done[i]};
      tests++;
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s inst%0d cyc%0d observed=%b expected=%b", tag, i, cyc, obs, exp);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk44kHz);
    model_edge();
    cyc++;
    @(negedge clk44kHz);
    check_all(tag);
  endtask

  int last_done;
  int gap;

  initial begin
    for (int i = 0; i < 3; i++) begin
      age[i]  = 0;
      word[i] = '0;
    end
    reset = 1'b1;
    load  = 1'b0;
    dato4 = '0;
    dato8 = '0;
    #1;
    check_all("reset_state");
    @(negedge clk44kHz);
    reset = 1'b0;
    step("idle_after_reset");

    // Load 1011 / 8'h81 and let all three streams complete.
    load  = 1'b1;
    dato4 = 4'b1011;
    dato8 = 8'h81;
    step("load_1011");
    load  = 1'b0;
    dato4 = 4'b0000;
    dato8 = 8'h00;
    for (int k = 0; k < 12; k++) step("stream_1011");

    // A load during the 2nd bit is ignored.
    load  = 1'b1;
    dato4 = 4'b1100;
    dato8 = 8'h3C;
    step("load_1100");
    load  = 1'b0;
    dato4 = 4'b0110;
    dato8 = 8'hFF;
    load  = 1'b1;
    step("ignored_load");
    load  = 1'b0;
    for (int k = 0; k < 10; k++) step("stream_1100");

    // Reset during the 3rd bit aborts at once without a done pulse.
    load  = 1'b1;
    dato4 = 4'b1111;
    dato8 = 8'hFF;
    step("load_1111");
    load = 1'b0;
    step("bit2_1111");
    step("bit3_1111");
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) age[i] = 0;
    check_all("reset_mid_shift");
    #2;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) step("after_abort");

    // Load held high, data alternating A/5 per accepted word.
    load      = 1'b1;
    dato4     = 4'hA;
    dato8     = 8'hA5;
    last_done = -1;
    for (int k = 0; k < 26; k++) begin
      step("load_held");
      if (age[0] == 1) dato4 = (dato4 == 4'hA) ? 4'h5 : 4'hA;
      if (done[0] === 1'b1) begin
        if (last_done >= 0) begin
          gap = cyc - last_done;
          tests++;
          assert (gap === 6) else begin
            fails++;
            $error("FAIL done_spacing observed=%0d expected=%0d", gap, 6);
          end
        end
        last_done = cyc;
      end
    end
    load = 1'b0;
    for (int k = 0; k < 12; k++) step("drain");

    // Randomized load/data traffic.
    for (int k = 0; k < 400; k++) begin
      load  = ($urandom_range(0, 2) == 0);
      dato4 = 4'($urandom);
      dato8 = 8'($urandom);
      step("random");
    end
    load = 1'b0;
    for (int k = 0; k < 12; k++) step("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
